// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x4 keypad scanner.
//   - FSM state encoding (S_IDLE .. S_RELEASE); the four column states are
//     consecutive so a column index is a plain subtraction from S_COL0.
//   - COL_ALL / COL_NONE column drive patterns, CODE_W key code width.
//   - lowest_row(): index of the lowest set row bit.
package keypad_pkg;

    localparam int CODE_W = 4;

    localparam logic [3:0] COL_ALL  = 4'b1111;
    localparam logic [3:0] COL_NONE = 4'b0000;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COL0    = 3'd1;
    localparam logic [2:0] S_COL1    = 3'd2;
    localparam logic [2:0] S_COL2    = 3'd3;
    localparam logic [2:0] S_COL3    = 3'd4;
    localparam logic [2:0] S_KEY     = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    // Several keys in one column resolve to the lowest row.
    function automatic logic [1:0] lowest_row(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: qualifies the start of a scan on a stable S_Row.
// Ports:
//   clock   - block clock, rising edge
//   reset   - asynchronous active-high reset, clears the counter
//   S_Row   - synchronized any-row-active flag
//   enable  - high while the scanner sits in S_IDLE
//   done    - S_Row has been high for DEBOUNCE_CYCLES consecutive idle cycles
// Only instantiated when KEYPAD_DEBOUNCE_EN is defined.
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic S_Row,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = enable && S_Row && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        // done means the scanner leaves S_IDLE on this edge, so clear with it.
        if (!enable || !S_Row || done) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner.
// Ports:
//   clock  - block clock, rising edge
//   reset  - asynchronous active-high reset
//   S_Row  - synchronized any-row-active flag from the upstream synchronizer
//   Row    - raw row lines, bit k = row k
//   Col    - registered column drive, bit k = column k
//   Code   - registered {row, col} code of the last detected key
//   Valid  - registered one-cycle strobe marking a new Code
// Configuration: define KEYPAD_DEBOUNCE_EN to require S_Row to be stable for
// DEBOUNCE_CYCLES idle cycles before a scan starts; otherwise S_Row alone
// starts the scan.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              S_Row,
    input  logic [3:0]        Row,
    output logic [3:0]        Col,
    output logic [CODE_W-1:0] Code,
    output logic              Valid
);

    logic [2:0]        state_q, state_d;
    logic [3:0]        col_q, col_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              low_seen_q, low_seen_d;
    logic              start;
    logic [1:0]        scan_idx;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef KEYPAD_DEBOUNCE_EN
    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .S_Row (S_Row),
        .enable(state_q == S_IDLE),
        .done  (start)
    );
`else
    assign start = S_Row;
`endif

    assign scan_idx = 2'(state_q - S_COL0);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        low_seen_d = low_seen_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COL0;
            end
            S_COL0, S_COL1, S_COL2, S_COL3: begin
                if (Row != 4'b0000) begin
                    state_d = S_KEY;
                    code_d  = {lowest_row(Row), scan_idx};
                end else if (state_q == S_COL3) begin
                    // Nothing found in any column: spurious press.
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q + 3'd1;
                end
            end
            S_KEY: begin
                state_d    = S_RELEASE;
                low_seen_d = 1'b0;
            end
            S_RELEASE: begin
                // Two consecutive low samples absorb synchronizer latency.
                if (S_Row) begin
                    low_seen_d = 1'b0;
                end else if (low_seen_q) begin
                    state_d = S_IDLE;
                end else begin
                    low_seen_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        col_d   = COL_ALL;
        valid_d = (state_d == S_KEY);
        case (state_d)
            S_COL0:  col_d = 4'b0001;
            S_COL1:  col_d = 4'b0010;
            S_COL2:  col_d = 4'b0100;
            S_COL3:  col_d = 4'b1000;
            S_KEY:   col_d = col_q;
            default: col_d = COL_ALL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= COL_ALL;
            code_q     <= '0;
            valid_q    <= 1'b0;
            low_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            low_seen_q <= low_seen_d;
        end
    end

    assign Col   = col_q;
    assign Code  = code_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
// A small keypad model turns the driven column pattern into row lines; the
// expected key code and scan timing are derived from which keys are held.
module tb_keypad_scanner;

    localparam int DEB = 16;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int START = DEB;
`else
    localparam int START = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       S_Row;
    logic [3:0] Row;
    logic [3:0] Col;
    logic [3:0] Code;
    logic       Valid;

    logic [3:0] keys [4];   // keys[c] = rows held down in column c
    int passed = 0;
    int total  = 0;
    int valid_seen = 0;

    keypad_scanner #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .S_Row(S_Row),
        .Row  (Row),
        .Col  (Col),
        .Code (Code),
        .Valid(Valid)
    );

    always #5 clock = ~clock;

    always_comb begin
        Row = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (Col[c]) Row = Row | keys[c];
        end
    end

    always @(negedge clock) begin
        if (Valid === 1'b1) valid_seen = valid_seen + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
    endtask

    // Reference: first column with any key wins, lowest row in that column.
    function automatic logic [3:0] model_code(output int col);
        logic [3:0] code;
        col  = -1;
        code = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (col < 0 && keys[c] != 4'b0000) begin
                col = c;
                for (int r = 3; r >= 0; r--) begin
                    if (keys[c][r]) code = 4'(r * 4 + c);
                end
            end
        end
        return code;
    endfunction

    // Raise S_Row with the current keys held and check the whole scan.
    task automatic do_press(input string name, input int hold);
        int col;
        int v0;
        logic [3:0] exp_code;
        exp_code = model_code(col);
        v0 = valid_seen;
        S_Row = 1'b1;
        for (int i = 1; i < START; i++) begin
            tick();
            total++;
            if (Col !== 4'b1111) $display("FAIL %s debounce_wait Col=%b expected 1111", name, Col);
            else passed++;
        end
        for (int k = 0; k <= col; k++) begin
            tick();
            total++;
            if (Col !== 4'(1 << k) || Valid !== 1'b0)
                $display("FAIL %s walk%0d Col=%b Valid=%b expected Col=%b Valid=0",
                         name, k, Col, Valid, 4'(1 << k));
            else passed++;
        end
        tick();
        total++;
        if (Valid !== 1'b1 || Code !== exp_code || Col !== 4'(1 << col))
            $display("FAIL %s key Valid=%b Code=%h Col=%b expected Valid=1 Code=%h Col=%b",
                     name, Valid, Code, Col, exp_code, 4'(1 << col));
        else passed++;
        tick();
        total++;
        if (Valid !== 1'b0 || Col !== 4'b1111)
            $display("FAIL %s after_key Valid=%b Col=%b expected Valid=0 Col=1111",
                     name, Valid, Col);
        else passed++;
        repeat (hold) tick();
        total++;
        if (valid_seen - v0 != 1 || Code !== exp_code)
            $display("FAIL %s strobes=%0d Code=%h expected strobes=1 Code=%h",
                     name, valid_seen - v0, Code, exp_code);
        else passed++;
    endtask

    task automatic do_release();
        clear_keys();
        S_Row = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_keys();
        reset = 1'b1;
        S_Row = 1'b0;
        tick();
        tick();
        total++;
        if (Col !== 4'b1111 || Code !== 4'h0 || Valid !== 1'b0)
            $display("FAIL reset Col=%b Code=%h Valid=%b expected 1111/0/0", Col, Code, Valid);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if (Col !== 4'b1111 || Valid !== 1'b0)
            $display("FAIL reset_idle Col=%b Valid=%b expected 1111/0", Col, Valid);
        else passed++;
    endtask

    task automatic test_row1_col2();
        clear_keys();
        keys[2] = 4'b0010;
        do_press("row1_col2", 2);
        total++;
        if (Code !== 4'h6) $display("FAIL row1_col2_code Code=%h expected 6", Code);
        else passed++;
        do_release();
    endtask

    task automatic test_hold_release();
        int v0;
        clear_keys();
        keys[1] = 4'b1000;
        do_press("hold50", 50);
        v0 = valid_seen;
        // A single low cycle must not finish the release.
        S_Row = 1'b0;
        tick();
        S_Row = 1'b1;
        for (int i = 0; i < START + 3; i++) begin
            tick();
            total++;
            if (Col !== 4'b1111) $display("FAIL glitch_hold Col=%b expected 1111", Col);
            else passed++;
        end
        total++;
        if (valid_seen != v0) $display("FAIL glitch_retrigger strobes=%0d expected 0", valid_seen - v0);
        else passed++;
        do_release();
        total++;
        if (Col !== 4'b1111) $display("FAIL released Col=%b expected 1111", Col);
        else passed++;
        // Two low cycles later the scanner is idle: a new press scans at once.
        keys[0] = 4'b0100;
        do_press("after_release", 1);
        do_release();
    endtask

    task automatic test_spurious();
        int v0;
        logic [3:0] code0;
        clear_keys();
        v0 = valid_seen;
        code0 = Code;
        S_Row = 1'b1;
        repeat (START) tick();
        S_Row = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (Col !== 4'(1 << k)) $display("FAIL spurious_walk%0d Col=%b expected %b", k, Col, 4'(1 << k));
            else passed++;
            tick();
        end
        repeat (3) tick();
        total++;
        if (Col !== 4'b1111 || valid_seen != v0 || Code !== code0)
            $display("FAIL spurious_end Col=%b strobes=%0d Code=%h expected 1111/0/%h",
                     Col, valid_seen - v0, Code, code0);
        else passed++;
    endtask

    task automatic test_multi_row();
        clear_keys();
        keys[3] = 4'b0101;
        do_press("multi_row", 1);
        total++;
        if (Code !== 4'h3) $display("FAIL multi_row_code Code=%h expected 3", Code);
        else passed++;
        do_release();
    endtask

    task automatic test_random();
        int c;
        for (int n = 0; n < 10; n++) begin
            clear_keys();
            c = int'($urandom_range(0, 3));
            keys[c] = 4'($urandom_range(1, 15));
            for (int cc = c + 1; cc < 4; cc++) keys[cc] = 4'($urandom_range(0, 15));
            do_press("random", int'($urandom_range(0, 6)));
            do_release();
        end
    endtask

    task automatic test_reset_midscan();
        int v0;
        clear_keys();
        keys[3] = 4'b1000;
        v0 = valid_seen;
        S_Row = 1'b1;
        repeat (START + 2) tick();
        total++;
        if (Col !== 4'b0100) $display("FAIL midscan_col2 Col=%b expected 0100", Col);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (Col !== 4'b1111 || Code !== 4'h0 || Valid !== 1'b0)
            $display("FAIL midscan_abort Col=%b Code=%h Valid=%b expected 1111/0/0",
                     Col, Code, Valid);
        else passed++;
        S_Row = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        total++;
        if (valid_seen != v0 || Col !== 4'b1111)
            $display("FAIL midscan_after strobes=%0d Col=%b expected 0/1111", valid_seen - v0, Col);
        else passed++;
        clear_keys();
    endtask

`ifdef KEYPAD_DEBOUNCE_EN
    task automatic test_debounce();
        clear_keys();
        S_Row = 1'b1;
        repeat (10) tick();
        S_Row = 1'b0;
        tick();
        S_Row = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
            tick();
            total++;
            if (Col !== ((i == DEB) ? 4'b0001 : 4'b1111))
                $display("FAIL debounce_run%0d Col=%b", i, Col);
            else passed++;
        end
        S_Row = 1'b0;
        repeat (8) tick();
    endtask
`endif

    initial begin
        clear_keys();
        reset = 1'b1;
        S_Row = 1'b0;
        test_reset();
        test_row1_col2();
        test_hold_release();
        test_spurious();
        test_multi_row();
        test_random();
`ifdef KEYPAD_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_midscan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 16, number of consecutive cycles S_Row must be high before a scan starts (used only with KEYPAD_DEBOUNCE_EN).
- REQ-002: Port clock, input, 1, block clock; all state updates on the rising edge.
- REQ-003: Port reset, input, 1, asynchronous active-high reset.
- REQ-004: Port S_Row, input, 1, synchronized any-row-active flag from the upstream synchronizer.
- REQ-005: Port Row, input, 4, raw keypad row lines, one-hot when one key is pressed; bit k = row k.
- REQ-006: Port Col, output, 4, registered column drive; bit k = column k.
- REQ-007: Port Code, output, 4, registered hex code of the last detected key.
- REQ-008: Port Valid, output, 1, registered single-cycle strobe marking a new Code.

Function
- REQ-009: FSM states, each with its registered Col value:
  - S_IDLE: Col=4'b1111.
  - S_COL0: Col=4'b0001.
  - S_COL1: Col=4'b0010.
  - S_COL2: Col=4'b0100.
  - S_COL3: Col=4'b1000.
  - S_KEY: Col holds the detecting column.
  - S_RELEASE: Col=4'b1111.
- REQ-010: S_IDLE -> S_COL0 on the first rising edge where the start condition holds; otherwise stay in S_IDLE.
  - Without debounce, the start condition is S_Row=1.
  - With debounce, the start condition is debounce-qualified (REQ-018).
- REQ-011: In S_COLk with Row!=0, the next state is S_KEY and the block latches Code = {row_idx[1:0], k[1:0]}.
- REQ-012: Otherwise S_COLk steps to S_COL(k+1).
- REQ-013: S_COL3 with Row=0 returns to S_IDLE; this is a spurious press and produces no Valid.
- REQ-014: If several Row bits are set in S_COLk, row_idx is the lowest set bit index.
- REQ-015: Valid=1 for exactly the one cycle the FSM is in S_KEY; S_KEY always advances to S_RELEASE on the next edge.
- REQ-016: S_RELEASE -> S_IDLE only after S_Row=0 for 2 consecutive cycles, which covers synchronizer latency; a held key never re-triggers Valid.
- REQ-017: Code holds its value between Valid strobes; the latency from S_Row rising to Valid is 2 cycles (best case, col 0) to 5 cycles (col 3), plus debounce time when enabled.

Reset
- REQ-019: While reset is high:
  - state = S_IDLE.
  - Col = 4'b1111.
  - Code = 4'h0.
  - Valid = 0.
  - Debounce counter = 0.
- REQ-020: Asserting reset mid-scan or while in S_KEY SHALL abort immediately, with no Valid emitted afterward; scanning resumes from S_IDLE on the first edge after reset deasserts.

Configuration
- REQ-021: Macro KEYPAD_DEBOUNCE_EN selects the debounce behaviour.
  - Defined: a counter increments while in S_IDLE with S_Row=1, clears to 0 whenever S_Row=0, and the start condition is counter == DEBOUNCE_CYCLES-1 with S_Row=1.
  - Undefined: no counter is built and the start condition is S_Row=1.
- REQ-018: With KEYPAD_DEBOUNCE_EN defined, the counter saturates and clears on leaving S_IDLE.

Structure
- REQ-022: Shared package keypad_pkg SHALL hold:
  - the state enumeration;
  - constants COL_ALL=4'b1111, COL_NONE=4'b0000 and CODE_W=4.
- REQ-023: The debounce counter SHALL be the sub-module keypad_debounce (inputs clock, reset, S_Row, enable; output done), instantiated only under KEYPAD_DEBOUNCE_EN.

Verification
- REQ-024: The bench SHALL cover these directed scenarios:
  - Press row1/col2 (debounce off) -> Col walks 0001,0010,0100; Code=4'h6; Valid high exactly 1 cycle.
  - Hold key 50 cycles then release -> single Valid; S_IDLE reached 2 cycles after S_Row falls; Col=1111.
  - S_Row pulse with Row=0 throughout scan -> walk S_COL0..S_COL3, return to S_IDLE, Valid never asserted.
  - Rows 0 and 2 set at col 3 -> Code=4'h3 (lowest row).
  - KEYPAD_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
    - S_Row high 10 cycles, low 1, then high 16 -> scan starts only after the 16-cycle run.
  - Reset asserted in S_COL2 -> Col=1111, Code=0, Valid=0 immediately; no Valid after release.
